// File: rtl/mult_seq_if.sv
// Request/result bundle for the sequential 32x32 multiplier.
// The slave side is the multiplier; the master side issues operands and collects the product.
interface mult_seq_if;
    logic        i_start;
    logic        i_sign;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_start, i_sign, i_a, i_b,
        input  o_hi, o_lo, o_busy, o_done
    );

    modport slave (
        input  i_start, i_sign, i_a, i_b,
        output o_hi, o_lo, o_busy, o_done
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential 32x32 -> 64 shift-add multiplier.
// Supports signed and unsigned operands, with one multiplier bit consumed per clock.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | 32 shift-add iterations, busy high
//   DONE   | one-cycle done pulse, new hi/lo valid; start here chains next op
module mult_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    mult_seq_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_mcand;
    logic [63:0] r_acc;
    logic [31:0] r_mplier;
    logic        r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;

    // A negated 0x80000000 stays 0x80000000, which is exactly the magnitude 2^31 as unsigned.
    assign w_a_mag    = (bus.i_sign && bus.i_a[31]) ? (~bus.i_a + 32'd1) : bus.i_a;
    assign w_b_mag    = (bus.i_sign && bus.i_b[31]) ? (~bus.i_b + 32'd1) : bus.i_b;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
    assign w_prod     = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;
    assign w_last     = (r_cnt == 5'd31);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= 5'd0;
            r_mcand  <= 64'd0;
            r_acc    <= 64'd0;
            r_mplier <= 32'd0;
            r_neg    <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (w_accept) begin
            r_cnt    <= 5'd0;
            r_mcand  <= {32'd0, w_a_mag};
            r_acc    <= 64'd0;
            r_mplier <= w_b_mag;
            r_neg    <= bus.i_sign & (bus.i_a[31] ^ bus.i_b[31]);
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt + 5'd1;
            r_mcand  <= r_mcand << 1;
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
        end
    end

    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
    assign bus.o_busy = (r_state == S_RUN);
    assign bus.o_done = (r_state == S_DONE);
endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq.
// Each task drives one scenario and compares against hand-computed products.
module tb_mult_seq;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    mult_seq_if bus ();

    mult_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start pulse; returns 1 ns after the accepting edge E0.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_sign  = s;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // Counts busy cycles until done is seen (bounded); stops sampled 1 ns after the done edge.
    task automatic wait_done(output int busy_cnt, output bit saw_done, output bit overlap);
        busy_cnt = 0;
        saw_done = 1'b0;
        overlap  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.o_busy && bus.o_done) overlap = 1'b1;
            if (bus.o_done) begin
                saw_done = 1'b1;
                break;
            end
            if (bus.o_busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_sign  = 1'b0;
        bus.i_a     = 32'd3;
        bus.i_b     = 32'd4;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.o_busy); else n_pass++;
        n_total++;
        if (bus.o_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.o_done); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'd0) $display("FAIL reset_hilo got=%h exp=0", {bus.o_hi, bus.o_lo}); else n_pass++;
        bus.i_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.o_busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", bus.o_busy); else n_pass++;
    endtask

    task automatic test_unsigned();
        int bc; bit sd; bit ov;
        launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(bc, sd, ov);
        n_total++;
        if (bc !== 32) $display("FAIL uns_busy_cycles got=%0d exp=32", bc); else n_pass++;
        n_total++;
        if (sd !== 1'b1) $display("FAIL uns_done_seen got=%b exp=1", sd); else n_pass++;
        n_total++;
        if (ov !== 1'b0) $display("FAIL uns_busy_done_overlap got=%b exp=0", ov); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'hFFFFFFFE_00000001)
            $display("FAIL uns_ffxff got=%h exp=fffffffe00000001", {bus.o_hi, bus.o_lo}); else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({bus.o_done, bus.o_busy} !== 2'b00) $display("FAIL uns_done_one_cycle got=%b exp=00", {bus.o_done, bus.o_busy}); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'hFFFFFFFE_00000001)
            $display("FAIL uns_hold got=%h exp=fffffffe00000001", {bus.o_hi, bus.o_lo}); else n_pass++;

        launch(1'b0, 32'h80000000, 32'd2);
        wait_done(bc, sd, ov);
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'h00000001_00000000)
            $display("FAIL uns_8000x2 got=%h exp=0000000100000000", {bus.o_hi, bus.o_lo}); else n_pass++;
    endtask

    task automatic test_signed();
        int bc; bit sd; bit ov;
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [63:0] ve [5];
        va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD; ve[0] = 64'hFFFFFFFF_FFFFFFEB;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; ve[1] = 64'h00000000_00000001;
        va[2] = 32'h80000000; vb[2] = 32'h80000000; ve[2] = 64'h40000000_00000000;
        va[3] = 32'h80000000; vb[3] = 32'd1;        ve[3] = 64'hFFFFFFFF_80000000;
        va[4] = 32'd0;        vb[4] = 32'hFFFFFFFD; ve[4] = 64'd0;
        for (int i = 0; i < 5; i++) begin
            launch(1'b1, va[i], vb[i]);
            wait_done(bc, sd, ov);
            n_total++;
            if (sd !== 1'b1 || bc !== 32)
                $display("FAIL sgn_timing[%0d] got busy=%0d done=%b exp busy=32 done=1", i, bc, sd); else n_pass++;
            n_total++;
            if ({bus.o_hi, bus.o_lo} !== ve[i])
                $display("FAIL sgn_product[%0d] got=%h exp=%h", i, {bus.o_hi, bus.o_lo}, ve[i]); else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int bc; bit sd; bit ov;
        logic [63:0] prev;
        prev = {bus.o_hi, bus.o_lo};
        launch(1'b0, 32'd3, 32'd5);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = 32'd9;
        bus.i_b     = 32'd9;
        bus.i_sign  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        n_total++;
        if (bus.o_busy !== 1'b1) $display("FAIL ign_busy_e10 got=%b exp=1", bus.o_busy); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== prev) $display("FAIL ign_hilo_hold got=%h exp=%h", {bus.o_hi, bus.o_lo}, prev); else n_pass++;
        wait_done(bc, sd, ov);
        n_total++;
        if (bc !== 22 || sd !== 1'b1) $display("FAIL ign_timing got busy=%0d done=%b exp busy=22 done=1", bc, sd); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'd15) $display("FAIL ign_product got=%h exp=f", {bus.o_hi, bus.o_lo}); else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({bus.o_done, bus.o_busy} !== 2'b00) $display("FAIL ign_single_done got=%b exp=00", {bus.o_done, bus.o_busy}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bc; bit sd; bit ov;
        launch(1'b0, 32'd3, 32'd5);
        wait_done(bc, sd, ov);
        n_total++;
        if (sd !== 1'b1 || {bus.o_hi, bus.o_lo} !== 64'd15)
            $display("FAIL b2b_first got done=%b prod=%h exp done=1 prod=f", sd, {bus.o_hi, bus.o_lo}); else n_pass++;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_sign  = 1'b0;
        bus.i_a     = 32'd2;
        bus.i_b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        n_total++;
        if ({bus.o_done, bus.o_busy} !== 2'b01) $display("FAIL b2b_rebusy got=%b exp=01", {bus.o_done, bus.o_busy}); else n_pass++;
        wait_done(bc, sd, ov);
        n_total++;
        if (bc !== 32 || sd !== 1'b1) $display("FAIL b2b_timing got busy=%0d done=%b exp busy=32 done=1", bc, sd); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'h00000001_FFFFFFFE)
            $display("FAIL b2b_product got=%h exp=00000001fffffffe", {bus.o_hi, bus.o_lo}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bc; bit sd; bit ov;
        bit done_seen;
        launch(1'b0, 32'd100, 32'd100);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.o_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", bus.o_busy); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'd0) $display("FAIL rstmid_hilo got=%h exp=0", {bus.o_hi, bus.o_lo}); else n_pass++;
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) done_seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) done_seen = 1'b1;
        end
        n_total++;
        if (done_seen !== 1'b0) $display("FAIL rstmid_no_done got=%b exp=0", done_seen); else n_pass++;
        launch(1'b1, 32'hFFFFFFFA, 32'd7);
        wait_done(bc, sd, ov);
        n_total++;
        if (bc !== 32 || sd !== 1'b1) $display("FAIL rstmid_after_timing got busy=%0d done=%b exp busy=32 done=1", bc, sd); else n_pass++;
        n_total++;
        if ({bus.o_hi, bus.o_lo} !== 64'hFFFFFFFF_FFFFFFD6)
            $display("FAIL rstmid_after_product got=%h exp=ffffffffffffffd6", {bus.o_hi, bus.o_lo}); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_sign  = 1'b0;
        bus.i_a     = 32'd0;
        bus.i_b     = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
